// File: rtl/crypt_pkg.sv
// Shared definitions for the stream cipher engine: key/byte widths and the
// controller state encoding.
package crypt_pkg;

    localparam int KEY_W  = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_FIN   = 3'd4
    } crypt_state_t;

endpackage

// File: rtl/stream_crypt.sv
// Stream cipher engine: XORs a message held in memory with a keystream from an
// external LFSR and writes the result to a destination region. Encryption and
// decryption are the same operation. One byte costs a READ and a WRITE cycle;
// the LFSR is seeded once per pass and stepped once per written byte.
module stream_crypt
    import crypt_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KEY_W-1:0]  seed,
    input  logic [LEN_W-1:0]  msgLen,
    input  logic [ADDR_W-1:0] srcBase,
    input  logic [ADDR_W-1:0] dstBase,
    output logic [ADDR_W-1:0] rdAddr,
    input  logic [BYTE_W-1:0] rdData,
    output logic              wrEn,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [BYTE_W-1:0] wrData,
    output logic              lfsrLd,
    output logic [KEY_W-1:0]  lfsrLdVal,
    output logic              lfsrStep,
    input  logic [BYTE_W-1:0] psrByte,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  byteCnt
);

    crypt_state_t      state;
    crypt_state_t      state_nx;

    // Pass parameters, frozen at start so the caller may change its inputs
    // while a pass runs.
    logic [KEY_W-1:0]  seed_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;

    // Byte index within the pass; doubles as the bytes-written count.
    logic [LEN_W-1:0]  idx;

    logic              accept;
    logic              last_byte;
    logic [ADDR_W-1:0] idx_addr;

    assign accept    = (state == ST_IDLE) && start;
    assign last_byte = (idx == (len_q - LEN_W'(1)));
    assign idx_addr  = ADDR_W'(idx);
    assign byteCnt   = idx;

    // State register; reset drops straight to IDLE so a pass in flight is
    // abandoned without a completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Byte index: cleared by every accepted start, advanced once per write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (accept) begin
            idx <= '0;
        end else if (state == ST_WRITE) begin
            idx <= idx + LEN_W'(1);
        end
    end

    // Capture pass parameters; every output that exposes them is gated by
    // state, so these need no reset.
    always_ff @(posedge clk) begin
        if (accept && (msgLen != '0)) begin
            seed_q <= seed;
            len_q  <= msgLen;
            src_q  <= srcBase;
            dst_q  <= dstBase;
        end
    end

    // Next-state and Moore outputs; all strobes and buses idle at zero.
    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        rdAddr    = '0;
        wrEn      = 1'b0;
        wrAddr    = '0;
        wrData    = '0;
        lfsrLd    = 1'b0;
        lfsrLdVal = '0;
        lfsrStep  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    // An empty message skips all memory and LFSR traffic.
                    state_nx = (msgLen == '0) ? ST_FIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy      = 1'b1;
                lfsrLd    = 1'b1;
                lfsrLdVal = seed_q;
                state_nx  = ST_READ;
            end
            ST_READ: begin
                busy     = 1'b1;
                rdAddr   = src_q + idx_addr;
                state_nx = ST_WRITE;
            end
            ST_WRITE: begin
                // rdData here answers the address presented in READ, and the
                // LFSR still holds the state for this byte until the step
                // takes effect at the end of the cycle.
                busy     = 1'b1;
                wrEn     = 1'b1;
                wrAddr   = dst_q + idx_addr;
                wrData   = rdData ^ psrByte;
                lfsrStep = 1'b1;
                state_nx = last_byte ? ST_FIN : ST_READ;
            end
            ST_FIN: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stream_crypt.sv
// Directed bench for stream_crypt with a byte memory and a 32-bit LFSR
// (x^32 + x^22 + x^2 + x + 1, keystream byte = low 8 bits of the state).
module tb_stream_crypt;

    localparam int ADDR_W = 8;
    localparam int LEN_W  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] seed;
    logic [7:0]  msgLen;
    logic [7:0]  srcBase;
    logic [7:0]  dstBase;
    logic [7:0]  rdAddr;
    logic [7:0]  rdData;
    logic        wrEn;
    logic [7:0]  wrAddr;
    logic [7:0]  wrData;
    logic        lfsrLd;
    logic [31:0] lfsrLdVal;
    logic        lfsrStep;
    logic [7:0]  psrByte;
    logic        busy;
    logic        done;
    logic [7:0]  byteCnt;

    stream_crypt #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .msgLen(msgLen),
        .srcBase(srcBase), .dstBase(dstBase), .rdAddr(rdAddr), .rdData(rdData),
        .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .lfsrLd(lfsrLd),
        .lfsrLdVal(lfsrLdVal), .lfsrStep(lfsrStep), .psrByte(psrByte),
        .busy(busy), .done(done), .byteCnt(byteCnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [7:0] ks_byte(input logic [31:0] s0, input int k);
        logic [31:0] s;
        s = s0;
        for (int i = 0; i < k; i++) s = lfsr_next(s);
        return s[7:0];
    endfunction

    // Memory with one-cycle read latency, plus a preload port for the bench.
    logic [7:0] mem [256];
    logic       pre_we;
    logic [7:0] pre_addr;
    logic [7:0] pre_data;
    always @(posedge clk) begin
        rdData <= mem[rdAddr];
        if (wrEn) mem[wrAddr] <= wrData;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end

    // External LFSR instance.
    logic [31:0] lfsr = 32'h0;
    always @(posedge clk) begin
        if (lfsrLd) lfsr <= lfsrLdVal;
        else if (lfsrStep) lfsr <= lfsr_next(lfsr);
    end
    assign psrByte = lfsr[7:0];

    // Activity log, sampled on the falling edge.
    logic [7:0] wr_a[$];
    logic [7:0] wr_d[$];
    logic [7:0] rd_a[$];
    logic [7:0] rd_prev = 8'h0;
    int ld_cnt = 0, step_cnt = 0, both_cnt = 0, done_cnt = 0, busy_fin_cnt = 0;
    always @(negedge clk) begin
        if (wrEn) begin
            wr_a.push_back(wrAddr);
            wr_d.push_back(wrData);
            rd_a.push_back(rd_prev);
        end
        if (lfsrLd) ld_cnt++;
        if (lfsrStep) step_cnt++;
        if (lfsrLd && lfsrStep) both_cnt++;
        if (done) done_cnt++;
        if (done && busy) busy_fin_cnt++;
        rd_prev <= rdAddr;
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk); #1;
        pre_we   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_wren"}, wrEn, 0);
        chk({tag, "_ld"}, lfsrLd, 0);
        chk({tag, "_step"}, lfsrStep, 0);
        chk({tag, "_cnt"}, byteCnt, 0);
        chk({tag, "_rda"}, rdAddr, 0);
        chk({tag, "_wra"}, wrAddr, 0);
        chk({tag, "_wrd"}, wrData, 0);
        chk({tag, "_ldv"}, lfsrLdVal, 0);
    endtask

    // Start a pass and return the edge count from acceptance to done (-1 on
    // timeout). With glitch set, start is re-pulsed mid-pass with different
    // inputs that must be ignored.
    task automatic run(input logic [31:0] s, input logic [7:0] n, input logic [7:0] src,
                       input logic [7:0] dst, input bit glitch, output int lat);
        lat = -1;
        @(negedge clk); #1;
        seed = s; msgLen = n; srcBase = src; dstBase = dst; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            start = glitch && (c == 3 || c == 6);
            if (start) begin
                seed = 32'hDEAD_BEEF; msgLen = 8'd2; srcBase = 8'hC0; dstBase = 8'hD0;
            end
            @(negedge clk); #1;
            start = 1'b0;
        end
    endtask

    logic [7:0] orig [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] src5 [5] = '{8'h01, 8'h80, 8'hFF, 8'h3C, 8'hA5};

    initial begin
        int lat, w0, l0, s0, d0;
        logic [7:0] e0, e1, e2;

        rst = 1'b1; start = 1'b0; seed = '0; msgLen = '0; srcBase = '0; dstBase = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("rst");
        rst = 1'b0;

        // Empty message: done after one edge, no traffic.
        w0 = wr_a.size(); l0 = ld_cnt; s0 = step_cnt;
        run(32'h1, 8'd0, 8'h00, 8'h00, 1'b0, lat);
        chk("len0_lat", 32'(lat), 1);
        chk("len0_busy", busy, 0);
        @(negedge clk); #1;
        chk("len0_done_pulse", done, 0);
        chk("len0_wr", 32'(wr_a.size() - w0), 0);
        chk("len0_ld", 32'(ld_cnt - l0), 0);
        chk("len0_step", 32'(step_cnt - s0), 0);

        // Four-byte encrypt 00..03 -> 40..43.
        for (int i = 0; i < 4; i++) poke(8'(i), orig[i]);
        w0 = wr_a.size(); l0 = ld_cnt; s0 = step_cnt;
        run(32'hA5A5_0001, 8'd4, 8'h00, 8'h40, 1'b0, lat);
        chk("enc_lat", 32'(lat), 10);
        chk("enc_cnt", byteCnt, 4);
        chk("enc_nwr", 32'(wr_a.size() - w0), 4);
        chk("enc_nld", 32'(ld_cnt - l0), 1);
        chk("enc_nstep", 32'(step_cnt - s0), 4);
        chk("enc_d0_hand", wr_d[w0], 8'h10);
        chk("enc_d1_hand", wr_d[w0 + 1], 8'h21);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("enc_a%0d", k), wr_a[w0 + k], 8'h40 + 8'(k));
            chk($sformatf("enc_d%0d", k), wr_d[w0 + k], orig[k] ^ ks_byte(32'hA5A5_0001, k));
        end
        @(negedge clk); #1;
        chk("enc_cnt_hold", byteCnt, 4);
        chk("enc_done_pulse", done, 0);

        // Decrypt 40..43 -> 80..83 with the same seed.
        run(32'hA5A5_0001, 8'd4, 8'h40, 8'h80, 1'b0, lat);
        chk("dec_lat", 32'(lat), 10);
        @(negedge clk); #1;
        for (int k = 0; k < 4; k++)
            chk($sformatf("dec_m%0d", k), mem[8'h80 + 8'(k)], orig[k]);

        // Wrapping, overlapping regions FE.. -> FF..
        poke(8'hFE, 8'h5A);
        poke(8'hFF, 8'hC3);
        poke(8'h00, 8'h11);
        e0 = 8'h5A ^ ks_byte(32'h1234_5678, 0);
        e1 = e0 ^ ks_byte(32'h1234_5678, 1);
        e2 = e1 ^ ks_byte(32'h1234_5678, 2);
        w0 = wr_a.size();
        run(32'h1234_5678, 8'd3, 8'hFE, 8'hFF, 1'b0, lat);
        chk("wrap_lat", 32'(lat), 8);
        chk("wrap_nwr", 32'(wr_a.size() - w0), 3);
        chk("wrap_r0", rd_a[w0], 8'hFE);
        chk("wrap_r1", rd_a[w0 + 1], 8'hFF);
        chk("wrap_r2", rd_a[w0 + 2], 8'h00);
        chk("wrap_w0", wr_a[w0], 8'hFF);
        chk("wrap_w1", wr_a[w0 + 1], 8'h00);
        chk("wrap_w2", wr_a[w0 + 2], 8'h01);
        chk("wrap_d0", wr_d[w0], e0);
        chk("wrap_d1", wr_d[w0 + 1], e1);
        chk("wrap_d2", wr_d[w0 + 2], e2);

        // Start re-pulsed mid-pass with altered inputs.
        for (int i = 0; i < 5; i++) poke(8'h10 + 8'(i), src5[i]);
        w0 = wr_a.size(); d0 = done_cnt;
        run(32'h0BAD_F00D, 8'd5, 8'h10, 8'h60, 1'b1, lat);
        chk("glitch_lat", 32'(lat), 12);
        chk("glitch_cnt", byteCnt, 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("glitch_a%0d", k), wr_a[w0 + k], 8'h60 + 8'(k));
            chk($sformatf("glitch_d%0d", k), wr_d[w0 + k], src5[k] ^ ks_byte(32'h0BAD_F00D, k));
        end
        repeat (4) @(negedge clk);
        #1;
        chk("glitch_nwr", 32'(wr_a.size() - w0), 5);
        chk("glitch_ndone", 32'(done_cnt - d0), 1);
        chk("glitch_idle", busy, 0);

        // Reset after the second write of a six-byte pass.
        w0 = wr_a.size(); d0 = done_cnt;
        @(negedge clk); #1;
        seed = 32'h5555_AAAA; msgLen = 8'd6; srcBase = 8'h20; dstBase = 8'h70; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 100 && (wr_a.size() - w0) < 2; c++) begin
            @(negedge clk); #1;
        end
        chk("abort_reach2", 32'(wr_a.size() - w0), 2);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk_all_zero("abort");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("abort_nwr", 32'(wr_a.size() - w0), 2);
        chk("abort_ndone", 32'(done_cnt - d0), 0);
        chk("abort_busy", busy, 0);

        chk("ld_step_overlap", 32'(both_cnt), 0);
        chk("done_while_busy", 32'(busy_fin_cnt), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
